// File: rtl/i2c_slave_ctrl.sv
// Byte-level I2C target: decodes START/STOP, matches SLV_ADDR, then receives
// bytes to the fabric or transmits fabric bytes to the master. No clock stretching.
module i2c_slave_ctrl #(
    parameter logic [6:0] SLV_ADDR = 7'h42
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
    } state_t;

    logic r_scl_s1, r_scl_s2, r_scl_h;
    logic r_sda_s1, r_sda_s2, r_sda_h;

    state_t     r_state, w_state;
    logic [2:0] r_cnt, w_cnt;
    logic [7:0] r_shift, w_shift;
    logic       r_sda_oe, w_sda_oe;
    logic       r_phase, w_phase;
    logic       r_busy, w_busy;
    logic       r_rw, w_rw;
    logic [7:0] r_rx_data, w_rx_data;
    logic       r_rx_valid, w_rx_valid;
    logic       r_tx_ack, w_tx_ack;
    logic       r_start_det, w_start_det;
    logic       r_stop_det, w_stop_det;

    logic w_scl_rise, w_scl_fall, w_scl_hi, w_start, w_stop, w_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_scl_h  <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_sda_h  <= 1'b1;
        end else begin
            r_scl_s1 <= SCL;
            r_scl_s2 <= r_scl_s1;
            r_scl_h  <= r_scl_s2;
            r_sda_s1 <= SDA;
            r_sda_s2 <= r_sda_s1;
            r_sda_h  <= r_sda_s2;
        end
    end

    // An SDA edge only counts as START/STOP when SCL is high in both samples,
    // so a simultaneous SCL/SDA change is treated as ordinary data.
    assign w_scl_rise = r_scl_s2 & ~r_scl_h;
    assign w_scl_fall = ~r_scl_s2 & r_scl_h;
    assign w_scl_hi   = r_scl_s2 & r_scl_h;
    assign w_start    = w_scl_hi & r_sda_h & ~r_sda_s2;
    assign w_stop     = w_scl_hi & ~r_sda_h & r_sda_s2;
    assign w_bit      = r_sda_s2;

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_shift     = r_shift;
        w_sda_oe    = r_sda_oe;
        w_phase     = r_phase;
        w_busy      = r_busy;
        w_rw        = r_rw;
        w_rx_data   = r_rx_data;
        w_rx_valid  = 1'b0;
        w_tx_ack    = 1'b0;
        w_start_det = 1'b0;
        w_stop_det  = 1'b0;

        case (r_state)
            IDLE: ;
            ADDR: begin
                if (w_scl_rise) begin
                    w_shift = {r_shift[6:0], w_bit};
                    w_cnt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_phase = 1'b0;
                        if (r_shift[6:0] == SLV_ADDR) begin
                            w_rw    = w_bit;
                            w_state = ADDR_ACK;
                        end else begin
                            w_state = WAIT_STOP;
                        end
                    end
                end
            end
            ADDR_ACK, RX_ACK: begin
                if (w_scl_fall) begin
                    if (!r_phase) begin
                        w_sda_oe = 1'b1;
                        w_phase  = 1'b1;
                        if (r_state == ADDR_ACK) w_busy = 1'b1;
                    end else begin
                        w_phase = 1'b0;
                        w_cnt   = 3'd0;
                        if (r_state == ADDR_ACK && r_rw) begin
                            w_shift  = tx_data;
                            w_tx_ack = 1'b1;
                            w_sda_oe = ~tx_data[7];
                            w_state  = TX_BYTE;
                        end else begin
                            w_sda_oe = 1'b0;
                            w_state  = RX_BYTE;
                        end
                    end
                end
            end
            RX_BYTE: begin
                if (w_scl_rise) begin
                    w_shift = {r_shift[6:0], w_bit};
                    w_cnt   = r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        w_rx_data  = {r_shift[6:0], w_bit};
                        w_rx_valid = 1'b1;
                        w_phase    = 1'b0;
                        w_state    = RX_ACK;
                    end
                end
            end
            TX_BYTE: begin
                if (w_scl_fall) begin
                    if (r_cnt == 3'd7) begin
                        w_sda_oe = 1'b0;
                        w_cnt    = 3'd0;
                        w_phase  = 1'b0;
                        w_state  = TX_ACK;
                    end else begin
                        w_cnt    = r_cnt + 3'd1;
                        w_shift  = {r_shift[6:0], r_shift[7]};
                        w_sda_oe = ~r_shift[6];
                    end
                end
            end
            TX_ACK: begin
                if (w_scl_rise && !r_phase) begin
                    if (w_bit) begin
                        w_busy  = 1'b0;
                        w_state = WAIT_STOP;
                    end else begin
                        w_phase = 1'b1;
                    end
                end else if (w_scl_fall && r_phase) begin
                    w_phase  = 1'b0;
                    w_shift  = tx_data;
                    w_tx_ack = 1'b1;
                    w_sda_oe = ~tx_data[7];
                    w_state  = TX_BYTE;
                end
            end
            WAIT_STOP: w_sda_oe = 1'b0;
            default:   w_state = IDLE;
        endcase

        // Bus conditions override whatever the byte engine decided this cycle.
        if (w_start) begin
            w_state     = ADDR;
            w_sda_oe    = 1'b0;
            w_cnt       = 3'd0;
            w_busy      = 1'b0;
            w_phase     = 1'b0;
            w_rx_valid  = 1'b0;
            w_tx_ack    = 1'b0;
            w_start_det = 1'b1;
        end else if (w_stop) begin
            w_state    = IDLE;
            w_sda_oe   = 1'b0;
            w_cnt      = 3'd0;
            w_busy     = 1'b0;
            w_phase    = 1'b0;
            w_rx_valid = 1'b0;
            w_tx_ack   = 1'b0;
            w_stop_det = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_sda_oe    <= 1'b0;
            r_phase     <= 1'b0;
            r_busy      <= 1'b0;
            r_rw        <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_tx_ack    <= 1'b0;
            r_start_det <= 1'b0;
            r_stop_det  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_shift     <= w_shift;
            r_sda_oe    <= w_sda_oe;
            r_phase     <= w_phase;
            r_busy      <= w_busy;
            r_rw        <= w_rw;
            r_rx_data   <= w_rx_data;
            r_rx_valid  <= w_rx_valid;
            r_tx_ack    <= w_tx_ack;
            r_start_det <= w_start_det;
            r_stop_det  <= w_stop_det;
        end
    end

    assign SDA       = r_sda_oe ? 1'b0 : 1'bz;
    assign tx_ack    = r_tx_ack;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rw        = r_rw;
    assign busy      = r_busy;
    assign start_det = r_start_det;
    assign stop_det  = r_stop_det;

endmodule
